// File: rtl/us_cmd_arbiter_pkg.sv
// us_cmd_arbiter_pkg
//   Shared definitions for the upstream command arbiter: command word width,
//   the position of the type field in a command word, the command type codes
//   and the arbiter state encoding. Imported by every us_cmd_arbiter file.
package us_cmd_arbiter_pkg;

  localparam int CMD_W       = 128;
  localparam int CMD_TYPE_HI = 63;
  localparam int CMD_TYPE_LO = 62;

  // Command type codes carried in cmd[63:62].
  localparam logic [1:0] US_CMD_WR32_TYPE = 2'b00;
  localparam logic [1:0] US_CMD_CPL_TYPE  = 2'b01;
  localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;
  localparam logic [1:0] US_CMD_INVALID   = 2'b11;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  // Extract the type field of a command word.
  function automatic logic [1:0] cmd_type(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_TYPE_HI:CMD_TYPE_LO];
  endfunction

  // True when a command carries the invalid type and must be dropped.
  function automatic logic cmd_is_invalid(input logic [CMD_W-1:0] cmd);
    return (cmd_type(cmd) == US_CMD_INVALID);
  endfunction

endpackage

// File: rtl/us_arb_rr_pick.sv
// us_arb_rr_pick
//   Combinational round-robin pick over the DMA requesters (indices
//   1..NUM_REQ-1). The search starts at ptr_i and wraps back to index 1;
//   bit 0 of elig_i (the completion class) is ignored.
// Ports:
//   elig_i  [NUM_REQ]  eligibility per requester
//   ptr_i   [IDX_W]    round-robin start index (1..NUM_REQ-1)
//   idx_o   [IDX_W]    selected DMA requester
//   found_o            some DMA requester is eligible
module us_arb_rr_pick
  import us_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0] dma_s;
  logic [NUM_REQ-1:0] upper_s;
  logic [NUM_REQ-1:0] pick_s;

  // Split candidates into those at/after the pointer and the wrapped rest;
  // the lowest set bit of the preferred half wins.
  always_comb begin
    dma_s   = elig_i & ~NUM_REQ'(1);
    upper_s = '0;
    for (int k = 1; k < NUM_REQ; k++) begin
      upper_s[k] = dma_s[k] & (IDX_W'(k) >= ptr_i);
    end
    pick_s  = (|upper_s) ? upper_s : dma_s;
    found_o = |dma_s;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      idx_o = pick_s[k] ? IDX_W'(k) : idx_o;
    end
  end

endmodule

// File: rtl/us_cmd_arbiter.sv
// us_cmd_arbiter
//   Shares the upstream command FIFO between NUM_REQ requesters. Requester 0
//   is the completion path and has priority; requesters 1..NUM_REQ-1 are DMA
//   sources served round-robin, with a starvation guard that forces a DMA
//   grant after STARVE_LIMIT lost IDLE cycles. Commands of invalid type are
//   acknowledged and dropped (counted in drop_cnt_o) without a FIFO write.
//   One command is issued every two cycles (IDLE -> ISSUE -> IDLE).
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_i   [NUM_REQ]             requests, held with stable cmd until gnt
//   cmd_i   [NUM_REQ*128]         command words, requester k at [128k+:128]
//   gnt_o   [NUM_REQ]             one-cycle grant pulse
//   us_cmd_fifo_full_i            FIFO full
//   us_cmd_fifo_prog_full_i       FIFO programmable full
//   us_cmd_fifo_din_o [128]       registered command word
//   us_cmd_fifo_wr_en_o           FIFO write strobe
//   busy_o                        state is ISSUE
//   drop_cnt_o [CNT_W]            saturating count of dropped commands
//   grant_cnt_o [NUM_REQ*16]      per-requester write counters, only when
//                                 US_ARB_STATS_EN is defined
module us_cmd_arbiter
  import us_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic                     us_cmd_fifo_full_i,
  input  logic                     us_cmd_fifo_prog_full_i,
  output logic [CMD_W-1:0]         us_cmd_fifo_din_o,
  output logic                     us_cmd_fifo_wr_en_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         drop_cnt_o
`ifdef US_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int ST_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CMD_W-1:0]   din_q, din_d;
  logic               wr_en_q, wr_en_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [NUM_REQ-1:0] elig_s;
  logic               dma_req_s;
  logic [IDX_W-1:0]   dma_win_s;
  logic               dma_found_s;
  logic [IDX_W-1:0]   win_s;
  logic               win_valid_s;
  logic [CMD_W-1:0]   sel_cmd_s;
  logic               sel_inv_s;

  // Eligibility: invalid commands bypass the FIFO level checks since they
  // are never written; DMA sources also back off on prog_full.
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (k == 0) begin
        elig_s[k] = req_i[k] & (~us_cmd_fifo_full_i |
                                cmd_is_invalid(cmd_i[k*CMD_W +: CMD_W]));
      end else begin
        elig_s[k] = req_i[k] & ((~us_cmd_fifo_full_i & ~us_cmd_fifo_prog_full_i) |
                                cmd_is_invalid(cmd_i[k*CMD_W +: CMD_W]));
      end
    end
    dma_req_s = |(req_i & ~NUM_REQ'(1));
  end

  us_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .elig_i  (elig_s),
    .ptr_i   (rr_ptr_q),
    .idx_o   (dma_win_s),
    .found_o (dma_found_s)
  );

  // Winner selection: starved DMA first, then completions, then DMA.
  always_comb begin
    win_s       = '0;
    win_valid_s = 1'b0;
    if ((starve_q >= ST_W'(STARVE_LIMIT)) && dma_found_s) begin
      win_s       = dma_win_s;
      win_valid_s = 1'b1;
    end else if (elig_s[0]) begin
      win_s       = '0;
      win_valid_s = 1'b1;
    end else begin
      win_s       = dma_win_s;
      win_valid_s = dma_found_s;
    end
    sel_cmd_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_cmd_s = sel_cmd_s |
                  ({CMD_W{win_s == IDX_W'(k)}} & cmd_i[k*CMD_W +: CMD_W]);
    end
    sel_inv_s = cmd_is_invalid(sel_cmd_s);
  end

  // Next-state logic. Grant, write strobe and din are loaded on the
  // IDLE->ISSUE edge so they are visible, registered, during ISSUE.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    gnt_d    = '0;
    wr_en_d  = 1'b0;
    din_d    = din_q;
    drop_d   = drop_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid_s) begin
          state_d = ARB_ISSUE;
          gnt_d   = NUM_REQ'(1) << win_s;
          if (sel_inv_s) begin
            drop_d = (drop_q == {CNT_W{1'b1}}) ? drop_q : drop_q + CNT_W'(1);
          end else begin
            wr_en_d = 1'b1;
            din_d   = sel_cmd_s;
          end
        end else begin
          state_d = ARB_IDLE;
        end
        // A DMA win resets the guard; any other outcome with a DMA request
        // pending counts as a lost cycle.
        if (win_valid_s && (win_s != '0)) begin
          starve_d = '0;
          if (sel_inv_s) begin
            rr_ptr_d = rr_ptr_q;
          end else begin
            rr_ptr_d = (win_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : win_s + IDX_W'(1);
          end
        end else if (dma_req_s) begin
          starve_d = (starve_q >= ST_W'(STARVE_LIMIT)) ? starve_q : starve_q + ST_W'(1);
        end else begin
          starve_d = starve_q;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= IDX_W'(1);
      starve_q <= '0;
      gnt_q    <= '0;
      din_q    <= '0;
      wr_en_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
      din_q    <= din_d;
      wr_en_q  <= wr_en_d;
      drop_q   <= drop_d;
    end
  end

  assign gnt_o               = gnt_q;
  assign us_cmd_fifo_din_o   = din_q;
  assign us_cmd_fifo_wr_en_o = wr_en_q;
  assign busy_o              = (state_q == ARB_ISSUE);
  assign drop_cnt_o          = drop_q;

`ifdef US_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt_q;

  // Per-requester count of issued FIFO writes, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if ((state_q == ARB_IDLE) && win_valid_s && !sel_inv_s &&
            (win_s == IDX_W'(k))) begin
          grant_cnt_q[k*16 +: 16] <= grant_cnt_q[k*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
